// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants, stall encodings and the stall/bus-wait FSM state type.
package pipe_ctrl_pkg;

  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic BranchEnable = 1'b1;
  localparam logic RstEnable    = 1'b1;

  localparam logic [2:0] StallAll  = 3'b111;
  localparam logic [2:0] StallNone = 3'b000;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BUSWAIT = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  function automatic logic [2:0] stall_vec(input logic req);
    return req ? StallAll : StallNone;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt32.sv
// Free-running 32-bit wrapping event counter with enable.
module perf_cnt32
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) count_q <= '0;
    else                  count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall arbitration with bus-wait watchdog and stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq_i,
  input  logic        ex_stallreq_i,
  input  logic        bus_stallreq_i,
  input  logic        ex_branch_flag_i,
  input  logic        bus_err_clr_i,
  output logic [2:0]  stalled,
  output logic        bus_err_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  localparam logic [15:0] WaitLimit = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        id_req_eff;

  // A taken branch in EX squashes the wrong-path instruction in ID, so its hazard is moot.
  assign id_req_eff = id_stallreq_i && (ex_branch_flag_i != BranchEnable);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stalled = stall_vec(bus_stallreq_i || ex_stallreq_i || id_req_eff);
    unique case (state_q)
      ST_RUN: begin
        // The first wait cycle is counted on entry so the limit lands on cycle TIMEOUT_CYC-1.
        if (bus_stallreq_i) begin
          state_d = ST_BUSWAIT;
          wait_d  = 16'd1;
        end else begin
          wait_d  = '0;
        end
      end
      ST_BUSWAIT: begin
        if (!bus_stallreq_i) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WaitLimit) begin
          state_d = ST_TIMEOUT;
        end else begin
          wait_d  = wait_q + 16'd1;
        end
      end
      ST_TIMEOUT: begin
        stalled = StallAll;
        if (bus_err_clr_i) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus_err_o = (state_q == ST_TIMEOUT);

  perf_cnt32 u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (stalled != StallNone),
    .count_o (stall_cycles_o)
  );

  perf_cnt32 u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ex_branch_flag_i == BranchEnable),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, branch masking, bus watchdog and counters.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_req = 1'b0, ex_req = 1'b0, bus_req = 1'b0, br = 1'b0, clr = 1'b0;
  logic [2:0]  stalled;
  logic        bus_err;
  logic [31:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.TIMEOUT_CYC(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_stallreq_i    (id_req),
    .ex_stallreq_i    (ex_req),
    .bus_stallreq_i   (bus_req),
    .ex_branch_flag_i (br),
    .bus_err_clr_i    (clr),
    .stalled          (stalled),
    .bus_err_o        (bus_err),
    .stall_cycles_o   (stall_cycles),
    .flush_count_o    (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    // reset asserted mid-cycle, no edge needed
    #3 rst = 1'b1;
    #1;
    chk("rst_stalled", stalled, 3'b000);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_flush_cnt", flush_count, 32'd0);
    #4 rst = 1'b0;

    // single-cycle load-use stall
    id_req = 1'b1;
    #1 chk("id_stall", stalled, 3'b111);
    cyc();
    id_req = 1'b0;
    chk("id_stall_cnt", stall_cycles, 32'd1);
    #1 chk("id_released", stalled, 3'b000);

    // branch masks ID request
    id_req = 1'b1; br = 1'b1;
    #1 chk("br_mask_stalled", stalled, 3'b000);
    cyc();
    id_req = 1'b0; br = 1'b0;
    chk("br_mask_flush", flush_count, 32'd1);
    chk("br_mask_stall_cnt", stall_cycles, 32'd1);

    // bus wait of 255 cycles: no timeout
    cyc(); do_reset();
    bus_req = 1'b1;
    #1 chk("bus255_stalled", stalled, 3'b111);
    repeat (255) cyc();
    bus_req = 1'b0;
    #1;
    chk("bus255_err", bus_err, 1'b0);
    chk("bus255_stall_cnt", stall_cycles, 32'd255);
    chk("bus255_released", stalled, 3'b000);
    cyc();
    chk("bus255_err_after", bus_err, 1'b0);
    chk("bus255_cnt_after", stall_cycles, 32'd255);

    // bus wait of 300 cycles, then clear at cycle 310
    cyc(); do_reset();
    bus_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (k == 0 || k == 254 || k == 255 || k == 256 || k == 257 || k == 299)
        chk($sformatf("bus300_err_c%0d", k), bus_err, (k >= 256) ? 1'b1 : 1'b0);
      if (k == 0 || k == 299)
        chk($sformatf("bus300_stalled_c%0d", k), stalled, 3'b111);
      cyc();
    end
    bus_req = 1'b0;
    for (int k = 300; k < 310; k++) begin
      #1;
      if (k == 300 || k == 309) begin
        chk($sformatf("timeout_stalled_c%0d", k), stalled, 3'b111);
        chk($sformatf("timeout_err_c%0d", k), bus_err, 1'b1);
      end
      cyc();
    end
    clr = 1'b1;
    #1;
    chk("clr_cycle_stalled", stalled, 3'b111);
    chk("clr_cycle_err", bus_err, 1'b1);
    cyc();
    clr = 1'b0;
    #1;
    chk("after_clr_err", bus_err, 1'b0);
    chk("after_clr_stalled", stalled, 3'b000);
    chk("after_clr_stall_cnt", stall_cycles, 32'd311);

    // clear together with a live bus request: fresh count afterwards
    cyc(); do_reset();
    bus_req = 1'b1;
    for (int k = 0; k < 515; k++) begin
      clr = (k == 257) ? 1'b1 : 1'b0;
      #1;
      if (k == 256 || k == 257) chk($sformatf("reclr_err_c%0d", k), bus_err, 1'b1);
      if (k == 258) begin
        chk("reclr_err_c258", bus_err, 1'b0);
        chk("reclr_stalled_c258", stalled, 3'b111);
      end
      if (k == 513) chk("reclr_err_c513", bus_err, 1'b0);
      if (k == 514) chk("reclr_err_c514", bus_err, 1'b1);
      cyc();
    end
    clr = 1'b0;
    chk("reclr_stall_cnt", stall_cycles, 32'd515);
    // asynchronous reset while in TIMEOUT with request still high
    rst = 1'b1;
    #1;
    chk("async_rst_err", bus_err, 1'b0);
    chk("async_rst_stall_cnt", stall_cycles, 32'd0);
    chk("async_rst_stalled", stalled, 3'b111);
    rst = 1'b0; bus_req = 1'b0;
    #1 chk("async_rst_idle", stalled, 3'b000);

    // EX busy while branches resolve
    cyc(); do_reset();
    ex_req = 1'b1; id_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      br = (k % 2 == 0) ? 1'b1 : 1'b0;
      #1 chk($sformatf("ex_br_stalled_c%0d", k), stalled, 3'b111);
      cyc();
    end
    br = 1'b0;
    chk("ex_br_flush", flush_count, 32'd3);
    chk("ex_br_stall_cnt", stall_cycles, 32'd6);
    rst = 1'b1;
    #1;
    chk("ex_rst_flush", flush_count, 32'd0);
    chk("ex_rst_stall_cnt", stall_cycles, 32'd0);
    rst = 1'b0; ex_req = 1'b0; id_req = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
